dram_mp_arbiter: RTL and testbench

Multi-port data memory for the multi-core processor: a single-ported synchronous RAM shared by `NUM_PORTS` cores through a round-robin arbiter with a per-port request/grant handshake. It generalises the single-core data RAM in data width, depth and port count. It adds an asynchronous reset, per-port read-valid strobes and out-of-range address detection. It sits between the core load/store units and the shared data store; one access completes per cycle.

---
 rtl/dram_mp_arbiter.sv | 89 ++++++++
 tb/tb_dram_mp_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/dram_mp_arbiter.sv
// Shared single-ported data RAM for multiple cores.
// Round-robin arbitration, one access per cycle.
module dram_mp_arbiter #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int DEPTH     = 1024,
  parameter int NUM_PORTS = 4,
  parameter     INIT_FILE = ""
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_PORTS-1:0]        req,
  input  logic [NUM_PORTS-1:0]        write_en,
  input  logic [NUM_PORTS*ADDR_W-1:0] addr,
  input  logic [NUM_PORTS*DATA_W-1:0] data_in,
  output logic [NUM_PORTS-1:0]        grant,
  output logic [NUM_PORTS*DATA_W-1:0] data_out,
  output logic [NUM_PORTS-1:0]        rd_valid,
  output logic [NUM_PORTS-1:0]        addr_err
);

  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] ram [DEPTH];

  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  sel;
  logic              gnt_any;
  int                p;

  always_comb begin
    sel     = '0;
    gnt_any = 1'b0;
    p       = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      p = (int'(rr_ptr) + i) % NUM_PORTS;
      if (!gnt_any && req[p] && rst_n) begin
        gnt_any = 1'b1;
        sel     = PTR_W'(p);
      end
    end
  end

  assign grant = gnt_any ? (NUM_PORTS'(1) << sel) : '0;

  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              sel_we;
  logic              in_range;
  logic [IDX_W-1:0]  idx;
  logic [PTR_W-1:0]  ptr_nxt;

  assign sel_addr = addr[int'(sel)*ADDR_W +: ADDR_W];
  assign sel_data = data_in[int'(sel)*DATA_W +: DATA_W];
  assign sel_we   = write_en[sel];
  assign in_range = {1'b0, sel_addr} < (ADDR_W+1)'(DEPTH);
  assign idx      = sel_addr[IDX_W-1:0];
  assign ptr_nxt  = PTR_W'((int'(sel) + 1) % NUM_PORTS);

  // RAM array carries no reset; grant is already gated by rst_n
  always_ff @(posedge clk) begin
    if (gnt_any && sel_we && in_range) begin
      ram[idx] <= sel_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      data_out <= '0;
      rd_valid <= '0;
      addr_err <= '0;
    end else begin
      rd_valid <= '0;
      addr_err <= '0;
      if (gnt_any) begin
        rr_ptr        <= ptr_nxt;
        addr_err[sel] <= !in_range;
        if (!sel_we) begin
          rd_valid[sel] <= 1'b1;
          data_out[int'(sel)*DATA_W +: DATA_W] <=
            in_range ? ram[idx] : '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_dram_mp_arbiter.sv
// Directed bench for dram_mp_arbiter with a read-data
// scoreboard and a reference round-robin model.
module tb_dram_mp_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [3:0]  write_en;
  logic [63:0] addr;
  logic [63:0] data_in;
  logic [3:0]  grant;
  logic [63:0] data_out;
  logic [3:0]  rd_valid;
  logic [3:0]  addr_err;

  dram_mp_arbiter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .write_en (write_en),
    .addr     (addr),
    .data_in  (data_in),
    .grant    (grant),
    .data_out (data_out),
    .rd_valid (rd_valid),
    .addr_err (addr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          port;
    logic [15:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] mem [1024];
  int          m_ptr;
  int          gcount [4];
  int          vectors;
  int          miscompares;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_port(input int pt, input logic we,
                          input logic [15:0] a,
                          input logic [15:0] d);
    write_en[pt]         = we;
    addr[pt*16 +: 16]    = a;
    data_in[pt*16 +: 16] = d;
  endtask

  // One clock: check grant against the model, then check
  // the registered results after the edge.
  task automatic cycle();
    logic [3:0]  eg;
    logic [3:0]  erdv;
    logic [3:0]  eerr;
    logic [15:0] a;
    exp_t        e;
    int          k;
    int          q;
    eg = '0; erdv = '0; eerr = '0; k = -1;
    #1;
    for (int i = 0; i < 4; i++) begin
      q = (m_ptr + i) % 4;
      if (k < 0 && req[q]) k = q;
    end
    if (k >= 0) eg[k] = 1'b1;
    chk("grant", {60'b0, grant}, {60'b0, eg});
    if (k >= 0) begin
      gcount[k]++;
      a = addr[k*16 +: 16];
      m_ptr = (k + 1) % 4;
      if (a >= 16'd1024) eerr[k] = 1'b1;
      if (write_en[k]) begin
        if (a < 16'd1024) mem[a[9:0]] = data_in[k*16 +: 16];
      end else begin
        erdv[k] = 1'b1;
        e.port = k;
        e.data = (a < 16'd1024) ? mem[a[9:0]] : 16'h0;
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    chk("rd_valid", {60'b0, rd_valid}, {60'b0, erdv});
    chk("addr_err", {60'b0, addr_err}, {60'b0, eerr});
    if (erdv != 0) begin
      if (sb.size() == 0) begin
        chk("sb_empty", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("data_out", {48'b0, data_out[e.port*16 +: 16]},
            {48'b0, e.data});
      end
    end
  endtask

  task automatic solo(input int pt, input logic we,
                      input logic [15:0] a,
                      input logic [15:0] d);
    req = '0;
    req[pt] = 1'b1;
    set_port(pt, we, a, d);
    cycle();
    req = '0;
  endtask

  initial begin
    vectors = 0; miscompares = 0; m_ptr = 0;
    for (int i = 0; i < 4; i++) gcount[i] = 0;
    rst_n = 1'b0; req = 4'b1111; write_en = '0;
    addr = '0; data_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant", {60'b0, grant}, 64'd0);
    chk("rst_rd_valid", {60'b0, rd_valid}, 64'd0);
    chk("rst_addr_err", {60'b0, addr_err}, 64'd0);
    chk("rst_data_out", data_out, 64'd0);

    // Fairness: all ports read out-of-range addresses
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) set_port(i, 1'b0, 16'(1024 + i), 16'h0);
    for (int c = 0; c < 8; c++) cycle();
    for (int i = 0; i < 4; i++)
      chk("fair_count", 64'(gcount[i]), 64'd2);
    req = '0;
    cycle();

    for (int i = 0; i < 1024; i++)
      solo(0, 1'b1, 16'(i), 16'(i * 3 + 1));

    solo(2, 1'b1, 16'd5, 16'h00AB);
    solo(2, 1'b0, 16'd5, 16'h0);
    chk("single_rd", {48'b0, data_out[47:32]}, 64'h00AB);
    cycle();

    // Pointer is at 3 here: expect 0, 2, 0
    req = 4'b0101;
    set_port(0, 1'b0, 16'd10, 16'h0);
    set_port(2, 1'b0, 16'd20, 16'h0);
    for (int c = 0; c < 3; c++) cycle();
    req = '0;

    solo(1, 1'b0, 16'd1024, 16'h0);
    solo(1, 1'b1, 16'd2000, 16'h1234);
    for (int i = 0; i < 1024; i++)
      solo(1, 1'b0, 16'(i), 16'h0);

    solo(0, 1'b1, 16'd7, 16'h0001);
    req = 4'b1000;
    set_port(3, 1'b1, 16'd7, 16'h5555);
    #1;
    chk("mid_grant", {60'b0, grant}, 64'h8);
    rst_n = 1'b0;
    #1;
    chk("mid_grant_rst", {60'b0, grant}, 64'd0);
    chk("mid_rd_valid", {60'b0, rd_valid}, 64'd0);
    chk("mid_data_out", data_out, 64'd0);
    @(posedge clk);
    #1;
    chk("mid_addr_err", {60'b0, addr_err}, 64'd0);
    chk("mid_data_out2", data_out, 64'd0);
    rst_n = 1'b1;
    req = '0;
    m_ptr = 0;
    solo(0, 1'b0, 16'd7, 16'h0);
    chk("mid_ram7", {48'b0, data_out[15:0]}, 64'h0001);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
